sb_bus_slave: RTL

- Parametrised successor to the first-generation southbridge bus monitor.
- Fully decodes Am386SX bus cycles on the local bus and terminates every cycle with READY# after a programmable number of wait states.
- Serves reads and writes to an internal scratch register window, acknowledges halt/shutdown, and flags the reset-vector fetch.
- Times out unclaimed cycles so the CPU never hangs. Sits between the CPU pins and the rest of the southbridge logic.

---
 rtl/sb_pkg.sv | 17 +
 rtl/sb_scratch_regs.sv | 29 ++
 rtl/sb_bus_slave.sv | 139 +++++++++++++
 3 files changed

// File: rtl/sb_pkg.sv
// Shared state encoding, cycle-type codes and defaults for the Am386SX bus slave.
package sb_pkg;

    typedef enum logic [1:0] {IDLE, DECODE, WAIT, ACK} state_t;

    // {M/IO#, D/C#, W/R#} cycle definitions
    localparam logic [2:0] CYC_INTA   = 3'b000;
    localparam logic [2:0] CYC_IO_RD  = 3'b010;
    localparam logic [2:0] CYC_IO_WR  = 3'b011;
    localparam logic [2:0] CYC_CODE   = 3'b100;
    localparam logic [2:0] CYC_HALT   = 3'b101;
    localparam logic [2:0] CYC_MEM_RD = 3'b110;
    localparam logic [2:0] CYC_MEM_WR = 3'b111;

    localparam logic [23:0] DEF_RESET_VECTOR = 24'hFF_FFF0;

endpackage

// File: rtl/sb_scratch_regs.sv
// DEPTH x 16 byte-writable scratch register file, combinational read, async reset.
module sb_scratch_regs #(
    parameter int DEPTH = 8,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             we,
    input  logic [1:0]       be_n,
    input  logic [IDX_W-1:0] idx,
    input  logic [15:0]      wdata,
    output logic [15:0]      rdata
);

    logic [15:0] mem [DEPTH];

    // NOTE: every word is in the async reset so the window reads zero after reset; that makes it flops, not a RAM macro.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we) begin
            if (!be_n[0]) mem[idx][7:0]  <= wdata[7:0];
            if (!be_n[1]) mem[idx][15:8] <= wdata[15:8];
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/sb_bus_slave.sv
// Am386SX local-bus slave: decodes cycles, serves a scratch window, terminates every cycle with READY#.
// Optional macro SB_DEBUG_EN adds a registered 16-bit debug port.
module sb_bus_slave
    import sb_pkg::*;
#(
    parameter int                ADDR_W       = 24,
    parameter int                DATA_W       = 16,
    parameter int                WAIT_STATES  = 2,
    parameter logic [ADDR_W-1:0] REG_BASE     = 24'h0F_0000,
    parameter int                REG_DEPTH    = 8,
    parameter int                TIMEOUT      = 64,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = DEF_RESET_VECTOR
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ads_n,
    input  logic              mio,
    input  logic              dc,
    input  logic              wr,
    input  logic [1:0]        be_n,
    input  logic [ADDR_W-1:1] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_oe,
    output logic              ready_n,
    output logic              na_n,
    output logic              boot_seen,
    output logic              halt_pulse,
    output logic              cycle_err
`ifdef SB_DEBUG_EN
    ,
    output logic [15:0]       debug
`endif
);

    localparam int IDX_W = $clog2(REG_DEPTH);
    localparam int CNT_W = ($clog2(TIMEOUT) + 1 < 6) ? 6 : $clog2(TIMEOUT) + 1;
    localparam logic [ADDR_W:0] REG_END = {1'b0, REG_BASE} + (ADDR_W+1)'(2 * REG_DEPTH);

    state_t            state;
    logic [ADDR_W-1:1] addr_q;
    logic [1:0]        be_q;
    logic [2:0]        cyc_q;
    logic [CNT_W-1:0]  cnt;

    logic [ADDR_W-1:0] byte_addr;
    logic [CNT_W-1:0]  cnt_init;
    logic [15:0]       reg_rdata;
    logic              is_hit, is_read, rd_load, reg_we;

    assign byte_addr = {addr_q, 1'b0};
    assign is_hit    = (cyc_q[2:1] == 2'b11)
                    && ({1'b0, byte_addr} >= {1'b0, REG_BASE})
                    && ({1'b0, byte_addr} <  REG_END);
    assign is_read   = ~cyc_q[0];
    assign cnt_init  = is_hit ? CNT_W'(WAIT_STATES - 1) : CNT_W'(TIMEOUT - 1);

    // Read data is staged one cycle before READY# so it is settled when the CPU samples it.
    assign rd_load = is_read && (((state == DECODE) && (cnt_init == '0))
                              || ((state == WAIT) && (cnt == CNT_W'(1))));
    assign reg_we  = (state == ACK) && is_hit && cyc_q[0];
    assign na_n    = 1'b1;

    sb_scratch_regs #(
        .DEPTH (REG_DEPTH),
        .IDX_W (IDX_W)
    ) u_regs (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (reg_we),
        .be_n    (be_q),
        .idx     (byte_addr[IDX_W:1]),
        .wdata   (data_in),
        .rdata   (reg_rdata)
    );

    // NOTE: all state here is registered, so only non-blocking assignments are used; blocking ones would race with readers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            addr_q     <= '0;
            be_q       <= '1;
            cyc_q      <= '0;
            cnt        <= '0;
            ready_n    <= 1'b1;
            data_oe    <= 1'b0;
            data_out   <= '0;
            boot_seen  <= 1'b0;
            halt_pulse <= 1'b0;
            cycle_err  <= 1'b0;
        end else begin
            halt_pulse <= 1'b0;
            if (rd_load) begin
                data_out <= is_hit ? reg_rdata : '1;
                data_oe  <= 1'b1;
            end
            case (state)
                IDLE: if (!ads_n) begin
                    addr_q <= addr;
                    be_q   <= be_n;
                    cyc_q  <= {mio, dc, wr};
                    state  <= DECODE;
                end
                DECODE: begin
                    if (cyc_q == CYC_CODE && byte_addr == RESET_VECTOR) boot_seen <= 1'b1;
                    if (cyc_q == CYC_HALT) begin
                        halt_pulse <= 1'b1;
                        ready_n    <= 1'b0;
                        state      <= ACK;
                    end else begin
                        cnt   <= cnt_init;
                        state <= WAIT;
                    end
                end
                WAIT: if (cnt == '0) begin
                    if (!is_hit) cycle_err <= 1'b1;
                    ready_n <= 1'b0;
                    state   <= ACK;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                ACK: begin
                    ready_n <= 1'b1;
                    data_oe <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SB_DEBUG_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) debug <= '0;
        else          debug <= {1'b0, state, cyc_q, cnt[5:0], boot_seen, cycle_err, halt_pulse, ready_n};
    end
`endif

endmodule
